// File: rtl/hexdump_pkg.sv
// Shared FSM state codes, ASCII character constants and nibble-to-hex helper
// for the hex dump line formatter.
package hexdump_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_COLON     = 4'd2;
  localparam logic [3:0] ST_BYTE_WAIT = 4'd3;
  localparam logic [3:0] ST_SP        = 4'd4;
  localparam logic [3:0] ST_HI        = 4'd5;
  localparam logic [3:0] ST_LO        = 4'd6;
  localparam logic [3:0] ST_ASCII     = 4'd7;
  localparam logic [3:0] ST_CR        = 4'd8;
  localparam logic [3:0] ST_LF        = 4'd9;
  localparam logic [3:0] ST_DONE      = 4'd10;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BAR   = 8'h7C;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // Upper-case hex digit: '0'..'9' then 'A'..'F' (0x37 + 10 = 'A').
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/hex_dump_formatter_if.sv
// UART transmitter side of the formatter: character, strobe and idle flag.
interface hex_dump_formatter_if;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_ready;

  modport master (output tx_data, output tx_write, input tx_ready);
  modport slave  (input tx_data, input tx_write, output tx_ready);
endinterface

// File: rtl/uart_char_pacer.sv
// Issues one-cycle tx_write strobes and reports a character as accepted once
// the transmitter is seen idle again after its strobe.
module uart_char_pacer (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_accept,
  hex_dump_formatter_if.master  uart
);

  logic       tx_write_q, tx_write_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       pending_q, pending_d;
  logic       strobe;

  // pending_q blocks a second strobe for the same character until it is accepted.
  always_comb begin
    tx_write_d  = 1'b0;
    tx_data_d   = tx_data_q;
    pending_d   = pending_q;
    strobe      = char_valid && !pending_q && !tx_write_q && uart.tx_ready;
    char_accept = pending_q && !tx_write_q && uart.tx_ready;
    if (strobe) begin
      tx_write_d = 1'b1;
      tx_data_d  = char_data;
      pending_d  = 1'b1;
    end
    if (char_accept) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_write_q <= 1'b0;
      tx_data_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
      pending_q  <= pending_d;
    end
  end

  assign uart.tx_write = tx_write_q;
  assign uart.tx_data  = tx_data_q;

endmodule

// File: rtl/hex_dump_formatter.sv
// Formats one flash line as "AAAAAA: BB BB ...\r\n" towards a UART.
// Define HEXDUMP_ASCII_EN to append the "  |....|" printable-character column.
module hex_dump_formatter
  import hexdump_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [7:0]  tx_data,
  output logic        tx_write,
  input  logic        tx_ready,
  output logic        busy,
  output logic        line_done
);

  localparam int unsigned IDXW      = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [5:0]  LAST_BYTE = 6'(BYTES_PER_LINE - 1);

  logic [3:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  line_buf_q [BYTES_PER_LINE];

  logic        buf_we;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_accept;
  logic [7:0]  cur_byte;
  logic [3:0]  addr_nib;

  hex_dump_formatter_if u_uart ();

  assign u_uart.tx_ready = tx_ready;
  assign tx_data         = u_uart.tx_data;
  assign tx_write        = u_uart.tx_write;

  uart_char_pacer u_pacer (
    .clk         (clk),
    .rstn        (rstn),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_accept (char_accept),
    .uart        (u_uart)
  );

  assign cur_byte = line_buf_q[cnt_q[IDXW-1:0]];

  always_comb begin
    case (idx_q[2:0])
      3'd0:    addr_nib = addr_q[23:20];
      3'd1:    addr_nib = addr_q[19:16];
      3'd2:    addr_nib = addr_q[15:12];
      3'd3:    addr_nib = addr_q[11:8];
      3'd4:    addr_nib = addr_q[7:4];
      3'd5:    addr_nib = addr_q[3:0];
      default: addr_nib = '0;
    endcase
  end

`ifdef HEXDUMP_ASCII_EN
  localparam logic [5:0] ASCII_LAST = 6'(BYTES_PER_LINE + 3);
  logic [5:0] asc_pos;
  logic [7:0] asc_byte;
  logic [7:0] asc_char;

  // ASCII column index: 0,1 spaces, 2 opening bar, 3.. bytes, last closing bar.
  assign asc_pos  = idx_q - 6'd3;
  assign asc_byte = line_buf_q[asc_pos[IDXW-1:0]];

  always_comb begin
    if (idx_q < 6'd2) begin
      asc_char = CH_SPACE;
    end else if (idx_q == 6'd2 || idx_q == ASCII_LAST) begin
      asc_char = CH_BAR;
    end else if (asc_byte >= 8'h20 && asc_byte <= 8'h7E) begin
      asc_char = asc_byte;
    end else begin
      asc_char = CH_DOT;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    buf_we     = 1'b0;
    char_valid = 1'b0;
    char_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          idx_d   = '0;
          cnt_d   = '0;
          addr_d  = base_addr;
        end
      end
      ST_ADDR: begin
        char_valid = 1'b1;
        char_data  = nib2hex(addr_nib);
        if (char_accept) begin
          if (idx_q == 6'd5) begin
            state_d = ST_COLON;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_COLON: begin
        char_valid = 1'b1;
        char_data  = CH_COLON;
        if (char_accept) state_d = ST_BYTE_WAIT;
      end
      ST_BYTE_WAIT: begin
        if (byte_valid) begin
          buf_we  = 1'b1;
          state_d = ST_SP;
        end
      end
      ST_SP: begin
        char_valid = 1'b1;
        char_data  = CH_SPACE;
        if (char_accept) state_d = ST_HI;
      end
      ST_HI: begin
        char_valid = 1'b1;
        char_data  = nib2hex(cur_byte[7:4]);
        if (char_accept) state_d = ST_LO;
      end
      ST_LO: begin
        char_valid = 1'b1;
        char_data  = nib2hex(cur_byte[3:0]);
        if (char_accept) begin
          cnt_d = cnt_q + 6'd1;
          idx_d = '0;
          if (cnt_q == LAST_BYTE) begin
`ifdef HEXDUMP_ASCII_EN
            state_d = ST_ASCII;
`else
            state_d = ST_CR;
`endif
          end else begin
            state_d = ST_BYTE_WAIT;
          end
        end
      end
`ifdef HEXDUMP_ASCII_EN
      ST_ASCII: begin
        char_valid = 1'b1;
        char_data  = asc_char;
        if (char_accept) begin
          if (idx_q == ASCII_LAST) state_d = ST_CR;
          else                     idx_d   = idx_q + 6'd1;
        end
      end
`endif
      ST_CR: begin
        char_valid = 1'b1;
        char_data  = CH_CR;
        if (char_accept) state_d = ST_LF;
      end
      ST_LF: begin
        char_valid = 1'b1;
        char_data  = CH_LF;
        if (char_accept) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) line_buf_q[cnt_q[IDXW-1:0]] <= byte_data;
  end

  assign byte_ready = (state_q == ST_BYTE_WAIT);
  assign line_done  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_hex_dump_formatter.sv
// Randomized self-checking bench: two formatters (4 and 1 bytes per line)
// compared against a string-level model of the expected dump line.
module tb_hex_dump_formatter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, sel, start, byte_valid, tx_ready;
  logic [23:0] base_addr;
  logic [7:0]  byte_data;
  logic        byte_ready, tx_write, busy, line_done;
  logic [7:0]  tx_data;

  logic        br4, busy4, ld4;
  logic        br1, tw1, busy1, ld1, tr1;
  logic [7:0]  td1;

  int total = 0;
  int fails = 0;

  hex_dump_formatter_if bus ();

  hex_dump_formatter #(.BYTES_PER_LINE(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start & ~sel), .base_addr(base_addr),
    .byte_valid(byte_valid & ~sel), .byte_data(byte_data), .byte_ready(br4),
    .tx_data(bus.tx_data), .tx_write(bus.tx_write), .tx_ready(bus.tx_ready),
    .busy(busy4), .line_done(ld4)
  );

  hex_dump_formatter #(.BYTES_PER_LINE(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start & sel), .base_addr(base_addr),
    .byte_valid(byte_valid & sel), .byte_data(byte_data), .byte_ready(br1),
    .tx_data(td1), .tx_write(tw1), .tx_ready(tr1),
    .busy(busy1), .line_done(ld1)
  );

  assign bus.tx_ready = sel ? 1'b1 : tx_ready;
  assign tr1          = sel ? tx_ready : 1'b1;
  assign byte_ready   = sel ? br1   : br4;
  assign tx_write     = sel ? tw1   : bus.tx_write;
  assign tx_data      = sel ? td1   : bus.tx_data;
  assign busy         = sel ? busy1 : busy4;
  assign line_done    = sel ? ld1   : ld4;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string hexs(input logic [23:0] v, input int nd);
    string digits = "0123456789ABCDEF";
    string s = "";
    int d;
    for (int k = 0; k < nd; k++) begin
      d = int'((v >> (4 * (nd - 1 - k))) & 24'hF);
      s = {s, digits.substr(d, d)};
    end
    return s;
  endfunction

  function automatic string expect_line(input logic [23:0] a, input logic [7:0] d[$]);
    string s;
    s = {hexs(a, 6), ":"};
    foreach (d[i]) s = {s, " ", hexs({16'h0, d[i]}, 2)};
`ifdef HEXDUMP_ASCII_EN
    s = {s, "  |"};
    foreach (d[i]) begin
      if (d[i] >= 8'd32 && d[i] <= 8'd126) s = {s, $sformatf("%c", d[i])};
      else                                 s = {s, "."};
    end
    s = {s, "|"};
`endif
    s = {s, "\r\n"};
    return s;
  endfunction

  task automatic run_line(input bit s, input logic [23:0] addr, input logic [7:0] data[$],
                          input int max_gap, input int stall, input bit poke_start,
                          input int rst_at);
    string exp, got;
    int bi = 0, gap = 0, xfers = 0, dones = 0, wide = 0, badrdy = 0, nch = 0;
    int busy_seen = 0, busy_at_done = 0, tail = -1, stall_left = 0, extra = 0;
    bit bv_prev, br_prev, tw_prev, tr_prev, finished = 0, aborted = 0;
    exp = expect_line(addr, data);
    got = "";
    sel = s;
    @(negedge clk);
    base_addr  = addr;
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = data[0];
    tx_ready   = 1'b1;
    bv_prev = 1'b1; br_prev = byte_ready; tw_prev = 1'b0; tr_prev = 1'b1;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_start && cyc == 30) begin
        start     = 1'b1;
        base_addr = 24'($urandom);
      end
      if (busy) busy_seen = 1;
      if (tx_write) begin
        got = {got, $sformatf("%c", tx_data)};
        nch++;
        if (tw_prev)  wide++;
        if (!tr_prev) badrdy++;
      end
      if (line_done) begin
        dones++;
        if (busy) busy_at_done++;
        if (tail < 0) tail = 6;
      end
      if (rst_at > 0 && nch == rst_at) begin
        aborted = 1;
        break;
      end
      if (bv_prev && br_prev) begin
        xfers++;
        bi++;
        gap = $urandom_range(max_gap, 0);
      end
      if (bi < data.size() && gap == 0) begin
        byte_valid = 1'b1;
        byte_data  = data[bi];
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        if (gap > 0) gap--;
      end
      if (tx_write) begin
        tx_ready   = 1'b0;
        stall_left = stall;
      end else if (stall_left > 0) begin
        stall_left--;
      end else begin
        tx_ready = 1'b1;
      end
      bv_prev = byte_valid; br_prev = byte_ready; tw_prev = tx_write; tr_prev = tx_ready;
      if (tail > 0) begin
        tail--;
        if (tail == 0) begin
          finished = 1;
          break;
        end
      end
    end
    if (aborted) begin
      rstn = 1'b0; start = 1'b0; byte_valid = 1'b0;
      @(negedge clk);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_tx_write", tx_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_tx_data", tx_data, 0);
      rstn = 1'b1; tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (tx_write || busy || line_done) extra++;
      end
      chk("rst_quiet", extra, 0);
    end else begin
      chk("timeout", finished, 1);
      chk("len", got.len(), exp.len());
      for (int i = 0; i < exp.len(); i++)
        chk($sformatf("char%0d", i), (i < got.len()) ? got[i] : 8'h00, exp[i]);
      chk("xfers", xfers, data.size());
      chk("line_done_cnt", dones, 1);
      chk("strobe_wide", wide, 0);
      chk("strobe_not_ready", badrdy, 0);
      chk("busy_seen", busy_seen, 1);
      chk("busy_at_done", busy_at_done, 0);
    end
    start = 1'b0; byte_valid = 1'b0; tx_ready = 1'b1;
  endtask

  logic [7:0] q[$];

  initial begin
    rstn = 1'b0; sel = 1'b0; start = 1'b0; byte_valid = 1'b0;
    byte_data = '0; tx_ready = 1'b1; base_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_byte_ready", byte_ready, 0);
    chk("reset_tx_write", tx_write, 0);
    chk("reset_busy", busy, 0);
    chk("reset_line_done", line_done, 0);
    chk("reset_tx_data", tx_data, 0);
    rstn = 1'b1;

    q = {8'h4A, 8'h6F, 8'h0A, 8'hFF};
    run_line(1'b0, 24'h400000, q, 0, 0, 1'b0, 0);
    q = {8'h00};
    run_line(1'b1, 24'hFFFFFF, q, 0, 2, 1'b0, 0);
    q = {8'h4A, 8'h6F, 8'h0A, 8'hFF};
    run_line(1'b0, 24'h400000, q, 20, 500, 1'b0, 0);

    q = {};
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    run_line(1'b0, 24'($urandom), q, 5, 3, 1'b1, 0);
    run_line(1'b0, 24'($urandom), q, 2, 1, 1'b0, 3);
    run_line(1'b0, 24'($urandom), q, 3, 2, 1'b0, 0);

    for (int n = 0; n < 6; n++) begin
      bit s;
      s = 1'($urandom);
      q = {};
      for (int i = 0; i < (s ? 1 : 4); i++) q.push_back(8'($urandom));
      run_line(s, 24'($urandom), q, $urandom_range(6, 0), $urandom_range(8, 0), 1'b0, 0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
